// File: rtl/max_row_sequencer_pkg.sv
// Shared score/value types and sequencer state encoding for the attention running-max path.
package max_row_sequencer_pkg;

  localparam int unsigned ScoreW = 16;
  localparam int unsigned VLanes = 4;
  localparam int unsigned VLaneW = 8;

  typedef logic signed [ScoreW-1:0]         score_qt_t;
  typedef logic [VLanes-1:0][VLaneW-1:0]    v_vector_t;

  // Most negative representable score; seeds every row's running max.
  localparam score_qt_t ScoreMin = {1'b1, {(ScoreW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain} seq_state_e;

endpackage

// File: rtl/max_row_sequencer_if.sv
// Score/value stream handshake between the producer and the running-max sequencer.
interface max_row_sequencer_if;
  import max_row_sequencer_pkg::*;

  logic      vld;
  logic      rdy;
  score_qt_t s;
  v_vector_t v;

  modport master (output vld, s, v, input rdy);
  modport slave  (input vld, s, v, output rdy);

endinterface

// File: rtl/max_row_sequencer.sv
// Streams per-row key scores into a one-entry max stage, forwarding m_prev and tagging row ends.
module max_row_sequencer
  import max_row_sequencer_pkg::*;
#(
  parameter int unsigned KEY_CNT_W = 16,
  parameter int unsigned ROW_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_CNT_W-1:0] num_keys,
  input  logic [ROW_CNT_W-1:0] num_rows,
  max_row_sequencer_if.slave   up,
  output logic                 stg_vld_in,
  input  logic                 stg_rdy,
  output score_qt_t            stg_s,
  output score_qt_t            stg_m_prev,
  output v_vector_t            stg_v,
  input  logic                 stg_vld_out,
  input  score_qt_t            stg_m_out,
  input  logic                 dn_rdy,
  output logic                 tag_last,
  output score_qt_t            row_max,
  output logic                 row_done,
  output logic                 busy,
  output logic                 done
);

  seq_state_e           state_q;
  logic [KEY_CNT_W-1:0] key_cnt_q, num_keys_q;
  logic [ROW_CNT_W-1:0] row_cnt_q, num_rows_q;
  logic                 first_q;
  logic                 tag_q;
  score_qt_t            m_run_q;

  logic run, in_fire, out_fire, key_last, row_last;

  assign run      = (state_q == StRun);
  assign in_fire  = up.vld && stg_rdy && run;
  assign out_fire = stg_vld_out && dn_rdy;
  assign key_last = (key_cnt_q == num_keys_q - KEY_CNT_W'(1));
  assign row_last = (row_cnt_q == num_rows_q - ROW_CNT_W'(1));

  assign up.rdy     = stg_rdy && run;
  assign stg_vld_in = up.vld && run;
  assign stg_s      = up.s;
  assign stg_v      = up.v;
  assign busy       = (state_q != StIdle);
  assign tag_last   = tag_q && stg_vld_out;

  // The stage holds at most one entry, so its live m_out is always the newest running max.
  assign stg_m_prev = first_q     ? ScoreMin  :
                      stg_vld_out ? stg_m_out : m_run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      key_cnt_q  <= '0;
      row_cnt_q  <= '0;
      num_keys_q <= '0;
      num_rows_q <= '0;
      first_q    <= 1'b0;
      tag_q      <= 1'b0;
      m_run_q    <= ScoreMin;
      row_max    <= ScoreMin;
      row_done   <= 1'b0;
      done       <= 1'b0;
    end else begin
      row_done <= 1'b0;
      done     <= 1'b0;

      if (out_fire) begin
        m_run_q <= tag_last ? ScoreMin : stg_m_out;
      end
      if (out_fire && tag_last) begin
        row_max  <= stg_m_out;
        row_done <= 1'b1;
      end

      // Tag follows the entry in the stage: a new entry overwrites, a pop clears.
      if (in_fire) begin
        tag_q <= key_last;
      end else if (dn_rdy) begin
        tag_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            num_keys_q <= num_keys;
            num_rows_q <= num_rows;
            key_cnt_q  <= '0;
            row_cnt_q  <= '0;
            first_q    <= 1'b1;
            if (num_keys == '0 || num_rows == '0) begin
              done <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (in_fire) begin
            if (key_last) begin
              key_cnt_q <= '0;
              row_cnt_q <= row_cnt_q + ROW_CNT_W'(1);
              first_q   <= 1'b1;
              if (row_last) begin
                state_q <= StDrain;
              end
            end else begin
              key_cnt_q <= key_cnt_q + KEY_CNT_W'(1);
              first_q   <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (!stg_vld_out || out_fire) begin
            state_q <= StIdle;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_max_row_sequencer.sv
// Closed-loop bench: sequencer plus a one-entry max stage, checked by a queue scoreboard.
module tb_max_row_sequencer;
  import max_row_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_keys = '0;
  logic [15:0] num_rows = '0;
  logic        dn_rdy = 1'b1;

  logic      stg_vld_in, stg_rdy, stg_vld_out, tag_last, row_done, busy, done;
  score_qt_t stg_s, stg_m_prev, stg_m_out, row_max;
  v_vector_t stg_v;

  max_row_sequencer_if up_if ();

  max_row_sequencer #(.KEY_CNT_W(16), .ROW_CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_keys    (num_keys),
    .num_rows    (num_rows),
    .up          (up_if),
    .stg_vld_in  (stg_vld_in),
    .stg_rdy     (stg_rdy),
    .stg_s       (stg_s),
    .stg_m_prev  (stg_m_prev),
    .stg_v       (stg_v),
    .stg_vld_out (stg_vld_out),
    .stg_m_out   (stg_m_out),
    .dn_rdy      (dn_rdy),
    .tag_last    (tag_last),
    .row_max     (row_max),
    .row_done    (row_done),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // One-entry running-max stage model.
  logic      stg_full;
  score_qt_t stg_m;
  assign stg_rdy     = !stg_full || dn_rdy;
  assign stg_vld_out = stg_full;
  assign stg_m_out   = stg_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_full <= 1'b0;
      stg_m    <= ScoreMin;
    end else if (stg_vld_in && stg_rdy) begin
      stg_full <= 1'b1;
      stg_m    <= (stg_s > stg_m_prev) ? stg_s : stg_m_prev;
    end else if (dn_rdy) begin
      stg_full <= 1'b0;
    end
  end

  bit rnd_dn = 1'b0;
  bit stall  = 1'b0;
  always @(posedge clk) begin
    #1;
    dn_rdy = rnd_dn ? ($urandom_range(0, 3) != 0) : !stall;
  end

  int n_vec = 0;
  int n_bad = 0;
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  score_qt_t exp_s[$], exp_mprev[$], exp_rowmax[$];
  bit        exp_tag[$];
  int        jq[$];
  int        issue_cnt = 0, rd_cnt = 0, done_cnt = 0;

  // Monitor: pops expectations whenever the DUT fires an issue, an output or a row_done.
  always @(negedge clk) begin
    if (!rst) begin
      if (stg_vld_in && stg_rdy) begin
        if (exp_s.size() == 0) begin
          check("unexpected_issue", 1, 0);
        end else begin
          check("stg_s", int'(stg_s), int'(exp_s.pop_front()));
          check("m_prev", int'(stg_m_prev), int'(exp_mprev.pop_front()));
        end
        issue_cnt++;
      end
      if (stg_vld_out && dn_rdy) begin
        if (exp_tag.size() == 0) check("unexpected_output", 1, 0);
        else check("tag_last", int'(tag_last), int'(exp_tag.pop_front()));
      end
      if (row_done) begin
        if (exp_rowmax.size() == 0) check("unexpected_row_done", 1, 0);
        else check("row_max", int'(row_max), int'(exp_rowmax.pop_front()));
        rd_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  // Reference: m_prev is the max of earlier keys in the row, SCORE_MIN for the first.
  task automatic expect_job(input int keys, input int rows);
    score_qt_t m, s;
    for (int r = 0; r < rows; r++) begin
      m = ScoreMin;
      for (int k = 0; k < keys; k++) begin
        s = score_qt_t'(jq[r*keys + k]);
        exp_s.push_back(s);
        exp_mprev.push_back(m);
        exp_tag.push_back(k == keys - 1);
        if (s > m) m = s;
      end
      exp_rowmax.push_back(m);
    end
  endtask

  task automatic pulse_start(input int keys, input int rows);
    num_keys = 16'(keys);
    num_rows = 16'(rows);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic send(input int val);
    int n;
    n = 0;
    up_if.vld = 1'b1;
    up_if.s   = score_qt_t'(val);
    up_if.v   = {score_qt_t'(val), ~score_qt_t'(val)};
    @(negedge clk);
    while (!up_if.rdy && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (n >= 400) check("send_timeout", n, 0);
    @(posedge clk); #1;
    up_if.vld = 1'b0;
  endtask

  task automatic run_job(input int keys, input int rows, input bit gaps);
    int d0, r0, n;
    expect_job(keys, rows);
    d0 = done_cnt;
    r0 = rd_cnt;
    pulse_start(keys, rows);
    foreach (jq[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(jq[i]);
    end
    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_count", done_cnt - d0, 1);
    check("row_done_count", rd_cnt - r0, rows);
    check("busy_after_done", int'(busy), 0);
    check("queues_drained", exp_s.size() + exp_tag.size() + exp_rowmax.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1);
  end

  initial begin
    int t1[4] = '{3, -2, 7, 5};
    int t2[4] = '{9, 1, -4, -6};
    int t3[3] = '{-1, 0, 2};
    int t4[6] = '{5, -8, 12, 4, 20, -3};
    int t5[4] = '{-5, -9, -1, -7};
    int d0, i0;

    up_if.vld = 1'b0;
    up_if.s   = '0;
    up_if.v   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_up_rdy", int'(up_if.rdy), 0);
    check("rst_row_max", int'(row_max), int'(ScoreMin));
    check("rst_tag_last", int'(tag_last), 0);
    check("rst_row_done", int'(row_done), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk); #1;

    // Single row, back-to-back: m_prev MIN,3,3,7; row_max 7.
    jq.delete(); foreach (t1[i]) jq.push_back(t1[i]);
    run_job(4, 1, 1'b0);

    // Two rows, no carry of the running max across rows.
    jq.delete(); foreach (t2[i]) jq.push_back(t2[i]);
    run_job(2, 2, 1'b0);

    // One key per row: every issue seeded with SCORE_MIN.
    jq.delete(); foreach (t3[i]) jq.push_back(t3[i]);
    run_job(1, 3, 1'b0);

    // Downstream stall mid-row.
    jq.delete(); foreach (t4[i]) jq.push_back(t4[i]);
    i0 = issue_cnt;
    fork
      run_job(6, 1, 1'b0);
      begin
        int n;
        n = 0;
        while (issue_cnt < i0 + 2 && n < 200) begin @(negedge clk); #1; n++; end
        stall = 1'b1;
        @(posedge clk); #2;
        repeat (5) begin
          @(negedge clk);
          check("stall_up_rdy", int'(up_if.rdy), 0);
        end
        stall = 1'b0;
      end
    join

    // Random gaps on both sides.
    jq.delete();
    for (int i = 0; i < 128; i++) jq.push_back(int'($urandom_range(0, 65535)) - 32768);
    rnd_dn = 1'b1;
    run_job(16, 8, 1'b1);
    rnd_dn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Zero-size job: immediate done, never busy.
    num_keys = 16'd0;
    num_rows = 16'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    @(negedge clk);
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    @(negedge clk);
    check("zero_done_width", int'(done), 0);
    @(posedge clk); #1;

    // Reset during key 2 of 4.
    jq.delete(); foreach (t1[i]) jq.push_back(t1[i]);
    expect_job(4, 1);
    pulse_start(4, 1);
    send(jq[0]);
    send(jq[1]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_s.delete(); exp_mprev.delete(); exp_tag.delete(); exp_rowmax.delete();
    d0 = done_cnt;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_row_max", int'(row_max), int'(ScoreMin));
    check("midrst_up_rdy", int'(up_if.rdy), 0);
    repeat (3) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);

    jq.delete(); foreach (t5[i]) jq.push_back(t5[i]);
    run_job(4, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
